vga_text_engine: RTL and testbench

Parametrised character-cell VGA display engine: generates VGA sync/blank timing, holds a writable COLS×ROWS character/attribute RAM, and renders each pixel with per-cell foreground/background colour and blink. It is the successor to the fixed-layout text controller. A host writes cells through a valid/ready port, and glyph bitmaps come from an external font ROM over a 1-cycle lookup port. It sits between the `clk_divider` 25 MHz output and the board DAC pins.

---
 rtl/vga_text_pkg.sv | 22 ++
 rtl/vga_timing_gen.sv | 63 ++++++
 rtl/vga_text_engine.sv | 166 ++++++++++++++++
 tb/tb_vga_text_engine.sv | 131 +++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared timing defaults, attribute layout, FSM encodings and sizing helper
package vga_text_pkg;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D = 33;
  localparam int ATTR_FG = 0;
  localparam int ATTR_BG = 3;
  localparam int ATTR_RSVD = 6;
  localparam int ATTR_BLINK = 7;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters with sync, active, frame start and frame end decode
module vga_timing_gen
  import vga_text_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW = clog2(H_TOTAL),
  localparam int YW = clog2(V_TOTAL)
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic active_o,
  output logic hsync_n_o,
  output logic vsync_n_o,
  output logic frame_start_o,
  output logic frame_end_o
);
  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_SS = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] X_SE = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_SS = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] Y_SE = YW'(V_ACTIVE + V_FP + V_SYNC);
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic x_wrap, y_wrap;
  assign x_wrap = x_q == X_LAST;
  assign y_wrap = y_q == Y_LAST;
  // x wraps every line; y advances on each x wrap and wraps every frame
  always_comb begin
    x_d = x_wrap ? '0 : x_q + 1'b1;
    y_d = !x_wrap ? y_q : y_wrap ? '0 : y_q + 1'b1;
  end
  // counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  assign x_o = x_q;
  assign y_o = y_q;
  assign active_o = x_q < X_ACT && y_q < Y_ACT;
  assign hsync_n_o = !(x_q >= X_SS && x_q < X_SE);
  assign vsync_n_o = !(y_q >= Y_SS && y_q < Y_SE);
  assign frame_start_o = x_q == '0 && y_q == '0;
  assign frame_end_o = x_wrap && y_wrap;
endmodule

// File: rtl/vga_text_engine.sv
// vga_text_engine: character-cell VGA renderer with host-writable cell RAM and external font ROM
module vga_text_engine
  import vga_text_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  parameter int GLYPH_W = 16,
  parameter int GLYPH_H = 32,
  parameter int COLS = H_ACTIVE / GLYPH_W,
  parameter int ROWS = V_ACTIVE / GLYPH_H,
  parameter int CODE_W = 8,
  parameter int BLINK_FRAMES = 32,
  parameter bit WR_BLANK_ONLY = 1'b0,
  localparam int CW = clog2(COLS),
  localparam int RW = clog2(ROWS),
  localparam int FXW = clog2(GLYPH_W),
  localparam int FYW = clog2(GLYPH_H)
) (
  input  logic VGA_clk,
  input  logic reset,
  input  logic wr_valid,
  output logic wr_ready,
  input  logic [CW-1:0] wr_col,
  input  logic [RW-1:0] wr_row,
  input  logic [CODE_W-1:0] wr_code,
  input  logic [7:0] wr_attr,
  output logic [CODE_W-1:0] font_code,
  output logic [FXW-1:0] font_x,
  output logic [FYW-1:0] font_y,
  input  logic font_bit,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic VGA_hSync,
  output logic VGA_vSync,
  output logic blank_n,
  output logic frame_start
);
  localparam int NC = COLS * ROWS;
  localparam int IW = clog2(NC);
  localparam int XW = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int YW = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int BW = clog2(BLINK_FRAMES);
  localparam int CELL_W = CODE_W + 7;
  localparam logic [IW-1:0] CLR_LAST = IW'(NC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  // pixel side-band bits: {active, hsync_n, vsync_n, frame_start, run, blink_phase}
  localparam logic [5:0] PIPE_IDLE = 6'b011000;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic active, hs_n, vs_n, fs, last;
  logic [0:0] state_q, state_d;
  logic [IW-1:0] clr_q, clr_d, rd_idx, wr_idx, ram_wa;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic phase_q, phase_d, clearing, in_range, ram_we, blink_wrap, on, rsvd_unused;
  logic [CELL_W-1:0] ram [NC];
  logic [CELL_W-1:0] cell_q, ram_wd;
  logic [5:0] s0, s1_q, s2_q;
  logic [FXW-1:0] fx_q;
  logic [FYW-1:0] fy_q;
  logic [6:0] attr2_q;
  logic [2:0] rgb, rgb_q;
  logic [3:0] out_q;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i(VGA_clk),
    .rst_i(reset),
    .x_o(x),
    .y_o(y),
    .active_o(active),
    .hsync_n_o(hs_n),
    .vsync_n_o(vs_n),
    .frame_start_o(fs),
    .frame_end_o(last)
  );

  assign clearing = state_q == ST_CLEAR;
  assign wr_ready = !clearing && !(WR_BLANK_ONLY && active);
  assign in_range = int'(wr_col) < COLS && int'(wr_row) < ROWS;
  assign wr_idx = IW'(int'(wr_row) * COLS + int'(wr_col));
  assign rd_idx = active ? IW'(int'(y[YW-1:FYW]) * COLS + int'(x[XW-1:FXW])) : '0;
  assign ram_we = clearing || (wr_valid && wr_ready && in_range);
  assign ram_wa = clearing ? clr_q : wr_idx;
  assign ram_wd = clearing ? '0 : {wr_attr[ATTR_BLINK], wr_attr[ATTR_BG +: 3], wr_attr[ATTR_FG +: 3], wr_code};
  assign rsvd_unused = wr_attr[ATTR_RSVD];
  assign blink_wrap = last && bcnt_q == BLINK_LAST;

  // clear sweep finishes on the last cell; blink phase flips after BLINK_FRAMES complete frames
  always_comb begin
    state_d = (clearing && clr_q == CLR_LAST) ? ST_RUN : state_q;
    clr_d = clearing ? clr_q + 1'b1 : clr_q;
    bcnt_d = blink_wrap ? '0 : last ? bcnt_q + 1'b1 : bcnt_q;
    phase_d = phase_q ^ blink_wrap;
  end

  // control state: clear/run mode, clear index, blink counter
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      clr_q <= '0;
      bcnt_q <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      bcnt_q <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  // simple dual-port cell RAM; a same-address read returns the pre-write contents
  always_ff @(posedge VGA_clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
    cell_q <= ram[rd_idx];
  end

  assign s0 = {active, hs_n, vs_n, fs, !clearing, phase_q};
  assign font_code = cell_q[CODE_W-1:0];
  assign font_x = fx_q;
  assign font_y = fy_q;

  // carry each pixel's side-band through the RAM read and font lookup stages
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      s1_q <= PIPE_IDLE;
      s2_q <= PIPE_IDLE;
      fx_q <= '0;
      fy_q <= '0;
      attr2_q <= '0;
    end else begin
      s1_q <= s0;
      s2_q <= s1_q;
      fx_q <= x[FXW-1:0];
      fy_q <= y[FYW-1:0];
      attr2_q <= cell_q[CODE_W +: 7];
    end
  end

  assign on = font_bit && !(attr2_q[6] && s2_q[0]);
  assign rgb = (s2_q[5] && s2_q[1]) ? (on ? attr2_q[2:0] : attr2_q[5:3]) : 3'b000;

  // output registers: colour, blank, syncs and frame start all for the same pixel
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      rgb_q <= '0;
      out_q <= 4'b0110;
    end else begin
      rgb_q <= rgb;
      out_q <= s2_q[5:2];
    end
  end

  assign VGA_R = {8{rgb_q[0]}};
  assign VGA_G = {8{rgb_q[1]}};
  assign VGA_B = {8{rgb_q[2]}};
  assign {blank_n, VGA_hSync, VGA_vSync, frame_start} = out_q;
endmodule

// File: tb/tb_vga_text_engine.sv
// tb_vga_text_engine: frame-level pixel model checked every cycle on an any-time-write and a blank-only-write engine
module tb_vga_text_engine;
  localparam int HA = 80, HF = 4, HS = 8, HB = 4, VA = 24, VF = 2, VS = 2, VB = 2;
  localparam int GW = 16, GH = 8, COLS = HA / GW, ROWS = VA / GH, NC = COLS * ROWS, BF = 2;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FT = HT * VT;
  localparam int RST_AT = 5 * FT + 12 * HT + 37, TOTAL = RST_AT + 2 * FT + 200;
  logic clk = 1'b0, rst = 1'b1, wr_valid = 1'b0;
  logic [2:0] wr_col = '0;
  logic [1:0] wr_row = '0;
  logic [7:0] wr_code = '0, wr_attr = '0;
  logic wr_ready [2];
  logic [7:0] font_code [2];
  logic [3:0] font_x [2];
  logic [2:0] font_y [2];
  logic font_bit [2];
  logic [7:0] vr [2], vg [2], vb [2];
  logic hs [2], vs [2], bn [2], fs [2];
  int checks = 0, errors = 0, c = 0;

  always #5 clk = ~clk;

  // glyph 0x41 lights even rows only; other non-zero codes form a checkerboard
  function automatic logic font_fn(input logic [7:0] code, input int fx, input int fy);
    return code == 8'h41 ? fy % 2 == 0 : code != 8'h00 && ((code[0] ^ code[3]) != ((fx + fy) % 2 == 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", tag, got, exp, c);
    end
  endtask

  for (genvar i = 0; i < 2; i++) begin : g_dut
    vga_text_engine #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .GLYPH_W(GW), .GLYPH_H(GH), .BLINK_FRAMES(BF), .WR_BLANK_ONLY(i == 1)
    ) dut (
      .VGA_clk(clk), .reset(rst), .wr_valid(wr_valid), .wr_ready(wr_ready[i]),
      .wr_col(wr_col), .wr_row(wr_row), .wr_code(wr_code), .wr_attr(wr_attr),
      .font_code(font_code[i]), .font_x(font_x[i]), .font_y(font_y[i]), .font_bit(font_bit[i]),
      .VGA_R(vr[i]), .VGA_G(vg[i]), .VGA_B(vb[i]), .VGA_hSync(hs[i]), .VGA_vSync(vs[i]),
      .blank_n(bn[i]), .frame_start(fs[i])
    );
    always_ff @(posedge clk) font_bit[i] <= font_fn(font_code[i], int'(font_x[i]), int'(font_y[i]));
  end

  initial begin
    logic [2:0] exp_rgb [2][4];
    logic [7:0] m_code [2][NC];
    logic [7:0] m_attr [2][NC];
    bit acc [2];
    bit exp_rdy [2];
    logic [2:0] d_col [4] = '{3'd3, 3'd4, 3'd5, 3'd0};
    logic [1:0] d_row [4] = '{2'd2, 2'd2, 2'd0, 2'd3};
    logic [7:0] d_code [4] = '{8'h41, 8'h41, 8'h55, 8'h55};
    logic [7:0] d_attr [4] = '{8'h0C, 8'h8C, 8'h3F, 8'h3F};
    logic [2:0] bits;
    int head, px, py, id, p, ex, ey;
    bit act, on;
    head = 0;
    acc = '{0, 0};
    for (int n = 0; n < TOTAL; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          for (int j = 0; j < NC; j++) begin
            m_code[k][j] = '0;
            m_attr[k][j] = '0;
          end
        end else if (acc[k] && int'(wr_col) < COLS && int'(wr_row) < ROWS) begin
          id = int'(wr_row) * COLS + int'(wr_col);
          m_code[k][id] = wr_code;
          m_attr[k][id] = wr_attr;
        end
      end
      c = rst ? 0 : c + 1;
      px = c % HT;
      py = (c / HT) % VT;
      act = px < HA && py < VA;
      for (int k = 0; k < 2; k++) begin
        bits = 3'b000;
        if (act && c >= NC) begin
          id = (py / GH) * COLS + px / GW;
          on = font_fn(m_code[k][id], px % GW, py % GH) && !(m_attr[k][id][7] && (c / FT / BF) % 2 == 1);
          bits = on ? m_attr[k][id][2:0] : m_attr[k][id][5:3];
        end
        exp_rgb[k][c % 4] = bits;
        if (c < 3) begin
          check($sformatf("idle_rgb%0d", k), {vr[k], vg[k], vb[k]}, 32'h0);
          check($sformatf("idle_ctl%0d", k), {hs[k], vs[k], bn[k], fs[k]}, 32'b1100);
        end else begin
          p = c - 3;
          ex = p % HT;
          ey = (p / HT) % VT;
          bits = exp_rgb[k][p % 4];
          check($sformatf("rgb%0d", k), {vr[k], vg[k], vb[k]}, {{8{bits[0]}}, {8{bits[1]}}, {8{bits[2]}}});
          check($sformatf("hsync%0d", k), hs[k], !(ex >= HA + HF && ex < HA + HF + HS));
          check($sformatf("vsync%0d", k), vs[k], !(ey >= VA + VF && ey < VA + VF + VS));
          check($sformatf("blank_n%0d", k), bn[k], ex < HA && ey < VA);
          check($sformatf("frame_start%0d", k), fs[k], ex == 0 && ey == 0);
        end
        exp_rdy[k] = c >= NC && !(k == 1 && act);
        check($sformatf("wr_ready%0d", k), wr_ready[k], exp_rdy[k]);
      end
      rst = n < 3 || n == RST_AT || n == RST_AT + 1;
      if (head < 4) begin
        wr_valid = 1'b1;
        wr_col = d_col[head];
        wr_row = d_row[head];
        wr_code = d_code[head];
        wr_attr = d_attr[head];
      end else if (n >= 4 * FT) begin
        wr_valid = $urandom_range(0, 3) == 0;
        wr_col = 3'($urandom_range(0, 7));
        wr_row = 2'($urandom_range(0, 3));
        wr_code = 8'($urandom);
        wr_attr = 8'($urandom);
      end else begin
        wr_valid = 1'b0;
      end
      for (int k = 0; k < 2; k++) acc[k] = wr_valid && exp_rdy[k];
      if (head < 4 && acc[1]) head++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
